// File: rtl/conv2_result_drain.sv
// conv2_result_drain: drains the conv2 accumulator bus. Each conv_time change
// snapshots the 16 x 30-bit accumulator word; channels are biased, rescaled,
// clamped and streamed one per beat over out_valid/out_ready.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   conv_data    - packed accumulators, channel 0 in the LSBs
//   conv_time    - producer position counter; any change marks a new word
//   b_en, b_in   - bias write strobe / signed bias, loaded in channel order
//   out_data     - signed result sample
//   out_ch       - channel index of out_data
//   out_valid    - sample valid
//   out_ready    - downstream accept
//   busy         - capture or emission in progress
//   overrun      - sticky: a word arrived while busy and was dropped
//   frame_done   - sticky: TOTAL_POS positions fully emitted
//
// Build option: define CONV2_DRAIN_RELU_EN to clamp to 0..127 (ReLU) instead
// of signed saturation to -128..127.
module conv2_result_drain #(
  parameter int CH         = 16,
  parameter int ACC_WIDTH  = 30,
  parameter int BIAS_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int FRAC_SHIFT = 9,
  parameter int TOTAL_POS  = 1260
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH*ACC_WIDTH-1:0] conv_data,
  input  logic [10:0]             conv_time,
  input  logic                    b_en,
  input  logic [BIAS_WIDTH-1:0]   b_in,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [3:0]              out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_done
);

  localparam int SW  = ACC_WIDTH + 2;
  localparam int BCW = $clog2(CH) + 1;
  localparam int PW  = $clog2(TOTAL_POS + 1);

  localparam logic [PW-1:0]  LAST_POS  = PW'(TOTAL_POS - 1);
  localparam logic [3:0]     LAST_CH   = 4'(CH - 1);
  localparam logic [BCW-1:0] BIAS_FULL = BCW'(CH);

  localparam logic signed [SW-1:0] OUT_MAX = SW'(2 ** (OUT_WIDTH - 1) - 1);
`ifndef CONV2_DRAIN_RELU_EN
  localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic [1:0] {IDLE, CAP, EMIT, DONE} state_t;

  state_t                       state;
  logic [10:0]                  last_time;
  logic [CH*ACC_WIDTH-1:0]      snap;
  logic signed [BIAS_WIDTH-1:0] bias [CH];
  logic [BCW-1:0]               bias_cnt;
  logic [PW-1:0]                pos_cnt;

  logic       conv_evt;
  logic [3:0] nxt_ch;
  logic       beat_acc;

  assign conv_evt = (conv_time != last_time);
  assign nxt_ch   = out_ch + 4'd1;
  assign beat_acc = out_valid && out_ready;

  // Bias is aligned to the accumulator's fixed point before the add, so the
  // floor shift afterwards is the only rounding step.
  function automatic logic [OUT_WIDTH-1:0] rescale(
    input logic [ACC_WIDTH-1:0]  acc_raw,
    input logic [BIAS_WIDTH-1:0] b_raw
  );
    logic signed [SW-1:0] acc_x;
    logic signed [SW-1:0] bias_x;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] scaled;
    logic [OUT_WIDTH-1:0] res;
    acc_x  = {{(SW-ACC_WIDTH){acc_raw[ACC_WIDTH-1]}}, acc_raw};
    bias_x = {{(SW-BIAS_WIDTH){b_raw[BIAS_WIDTH-1]}}, b_raw};
    sum    = acc_x + (bias_x <<< FRAC_SHIFT);
    scaled = sum >>> FRAC_SHIFT;
`ifdef CONV2_DRAIN_RELU_EN
    if (scaled < 0)
      res = '0;
    else if (scaled > OUT_MAX)
      res = OUT_MAX[OUT_WIDTH-1:0];
    else
      res = scaled[OUT_WIDTH-1:0];
`else
    if (scaled > OUT_MAX)
      res = OUT_MAX[OUT_WIDTH-1:0];
    else if (scaled < OUT_MIN)
      res = OUT_MIN[OUT_WIDTH-1:0];
    else
      res = scaled[OUT_WIDTH-1:0];
`endif
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_time  <= '0;
      snap       <= '0;
      bias_cnt   <= '0;
      pos_cnt    <= '0;
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < CH; i++)
        bias[i] <= '0;
    end else begin
      last_time <= conv_time;

      if (b_en && (bias_cnt != BIAS_FULL)) begin
        bias[bias_cnt[BCW-2:0]] <= b_in;
        bias_cnt                <= bias_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (conv_evt) begin
            snap  <= conv_data;
            state <= CAP;
            busy  <= 1'b1;
          end
        end

        CAP: begin
          if (conv_evt)
            overrun <= 1'b1;
          out_data  <= rescale(snap[ACC_WIDTH-1:0], bias[0]);
          out_ch    <= '0;
          out_valid <= 1'b1;
          state     <= EMIT;
        end

        EMIT: begin
          if (beat_acc && (out_ch == LAST_CH)) begin
            out_valid <= 1'b0;
            pos_cnt   <= pos_cnt + 1'b1;
            if (pos_cnt == LAST_POS) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else if (conv_evt) begin
              // word arriving with the final accept is taken, not dropped
              snap  <= conv_data;
              state <= CAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            if (conv_evt)
              overrun <= 1'b1;
            if (beat_acc) begin
              out_ch   <= nxt_ch;
              out_data <= rescale(snap[nxt_ch*ACC_WIDTH +: ACC_WIDTH], bias[nxt_ch]);
            end
          end
        end

        DONE: begin
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_result_drain.sv
module tb_conv2_result_drain;

  localparam int CH = 16;
  localparam int AW = 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*AW-1:0]  conv_data;
  logic [10:0]       conv_time;
  logic              b_en;
  logic [7:0]        b_in;
  logic [7:0]        out_data;
  logic [3:0]        out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              frame_done;

  conv2_result_drain #(
    .CH(16), .ACC_WIDTH(30), .BIAS_WIDTH(8), .OUT_WIDTH(8),
    .FRAC_SHIFT(9), .TOTAL_POS(1260)
  ) dut (
    .clk(clk), .rst_n(rst_n), .conv_data(conv_data), .conv_time(conv_time),
    .b_en(b_en), .b_in(b_in), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun(overrun), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {int ch; int data;} beat_t;
  beat_t beat_q[$];
  beat_t mon_b;

  // Bias model: loaded in order, extra strobes ignored.
  int mb[CH];
  int mb_cnt;

  // Beats are recorded on the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_b.ch   = int'(out_ch);
      mon_b.data = int'($signed(out_data));
      beat_q.push_back(mon_b);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: real-valued floor((acc + bias*512) / 512), then clamp.
  function automatic int model(input longint acc, input longint b);
    longint s, q;
    s = acc + b * 512;
    q = s / 512;
    if ((s % 512 != 0) && (s < 0)) q = q - 1;
`ifdef CONV2_DRAIN_RELU_EN
    if (q < 0) q = 0;
`else
    if (q < -128) q = -128;
`endif
    if (q > 127) q = 127;
    return int'(q);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    conv_time = '0;
    conv_data = '0;
    b_en      = 1'b0;
    b_in      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < CH; i++) mb[i] = 0;
    mb_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    beat_q.delete();
  endtask

  task automatic load_bias(input int v);
    b_in = v[7:0];
    b_en = 1'b1;
    step(1);
    b_en = 1'b0;
    if (mb_cnt < CH) begin
      mb[mb_cnt] = v;
      mb_cnt++;
    end
  endtask

  task automatic fire(input int acc[CH]);
    for (int i = 0; i < CH; i++) conv_data[i*AW +: AW] = acc[i][AW-1:0];
    conv_time = conv_time + 11'd1;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check({name, " beat count"}, beat_q.size(), n);
  endtask

  task automatic check_word(input string name, input int acc[CH], input int base);
    for (int i = 0; i < CH; i++) begin
      if (base + i < beat_q.size()) begin
        check($sformatf("%s ch%0d index", name, i), beat_q[base+i].ch, i);
        check($sformatf("%s ch%0d data", name, i), beat_q[base+i].data, model(acc[i], mb[i]));
      end
    end
  endtask

  function automatic int rand_acc();
    int v;
    case ($urandom_range(0, 2))
      0: begin
        v = int'($urandom);
        v = (v <<< 2) >>> 2;
      end
      1: v = int'($urandom_range(0, 131071)) - 65536;
      default: v = (int'($urandom_range(0, 255)) - 128) * 512 + int'($urandom_range(0, 2)) - 1;
    endcase
    return v;
  endfunction

  typedef struct {int acc; int exp_sat; int exp_relu;} vec_t;
  vec_t tbl[CH];

  initial begin
    int zero[CH];
    int wa[CH];
    int wb[CH];
    int k;
    int exp_v;
    int to_cnt;
    int vcnt;

    for (int i = 0; i < CH; i++) zero[i] = 0;
    rst_n = 1'b1;
    conv_time = '0;
    conv_data = '0;
    b_en = 1'b0;
    b_in = '0;
    out_ready = 1'b0;

    // ---------------- reset state
    do_reset();
    check("rst out_data", out_data, 0);
    check("rst out_ch", out_ch, 0);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);
    check("rst frame_done", frame_done, 0);

    // ---------------- table-driven arithmetic, biases 0
    tbl[0]  = '{2560, 5, 5};
    tbl[1]  = '{102400, 127, 127};
    tbl[2]  = '{-1536, -3, 0};
    tbl[3]  = '{-1, -1, 0};
    tbl[4]  = '{511, 0, 0};
    tbl[5]  = '{512, 1, 1};
    tbl[6]  = '{-512, -1, 0};
    tbl[7]  = '{65023, 126, 126};
    tbl[8]  = '{65024, 127, 127};
    tbl[9]  = '{65536, 127, 127};
    tbl[10] = '{-65536, -128, 0};
    tbl[11] = '{-65537, -128, 0};
    tbl[12] = '{536870911, 127, 127};
    tbl[13] = '{-536870912, -128, 0};
    tbl[14] = '{0, 0, 0};
    tbl[15] = '{-65025, -128, 0};
    for (int i = 0; i < CH; i++) wa[i] = tbl[i].acc;
    out_ready = 1'b1;
    fire(wa);
    wait_beats("table", 16, 40);
    for (int i = 0; i < CH; i++) begin
`ifdef CONV2_DRAIN_RELU_EN
      exp_v = tbl[i].exp_relu;
`else
      exp_v = tbl[i].exp_sat;
`endif
      if (i < beat_q.size()) begin
        check($sformatf("table ch%0d index", i), beat_q[i].ch, i);
        check($sformatf("table ch%0d data", i), beat_q[i].data, exp_v);
      end
    end

    // ---------------- bias load: 1..16 then 99 (ignored)
    do_reset();
    for (int v = 1; v <= 16; v++) load_bias(v);
    load_bias(99);
    out_ready = 1'b1;
    fire(zero);
    wait_beats("bias", 16, 40);
    for (int i = 0; i < CH && i < beat_q.size(); i++)
      check($sformatf("bias ch%0d data", i), beat_q[i].data, i + 1);

    // ---------------- backpressure and latency
    do_reset();
    out_ready = 1'b0;
    fire(zero);
    k = 0;
    while (!out_valid && k < 10) begin
      step(1);
      k++;
    end
    check("event-to-valid latency", k, 2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold cycle %0d {valid,ch,data}", c),
            {out_valid, out_ch, out_data}, 13'h1000);
      step(1);
    end
    out_ready = 1'b1;
    for (int c = 1; c < CH; c++) begin
      step(1);
      check($sformatf("bp b2b beat %0d {valid,ch}", c), {out_valid, out_ch}, {1'b1, 4'(c)});
    end
    step(1);
    check("bp valid after ch15", out_valid, 0);
    check("bp beat count", beat_q.size(), 16);

    // ---------------- new word arriving with the ch15 accept
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) wa[i] = rand_acc();
    for (int i = 0; i < CH; i++) wb[i] = rand_acc();
    fire(wa);
    k = 0;
    while (!(out_valid && out_ch == 4'd15) && k < 40) begin
      step(1);
      k++;
    end
    fire(wb);
    wait_beats("b2b", 32, 60);
    check("b2b overrun", overrun, 0);
    check_word("b2b word A", wa, 0);
    check_word("b2b word B", wb, 16);

    // ---------------- overrun
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) wa[i] = rand_acc();
    fire(wa);
    step(4);
    for (int i = 0; i < CH; i++) wb[i] = rand_acc();
    fire(wb);
    step(2);
    check("overrun set", overrun, 1);
    k = 0;
    while (busy && k < 40) begin
      step(1);
      k++;
    end
    step(3);
    check("overrun beats", beat_q.size(), 16);
    check_word("overrun word A", wa, 0);
    check("overrun sticky", overrun, 1);
    fire(wb);
    wait_beats("overrun third", 32, 40);
    check_word("overrun third word", wb, 16);
    check("overrun still set", overrun, 1);

    // ---------------- randomized words, random biases, random ready
    do_reset();
    for (int i = 0; i < CH; i++) load_bias(int'($urandom_range(0, 255)) - 128);
    for (int e = 0; e < 30; e++) begin
      for (int i = 0; i < CH; i++) wa[i] = rand_acc();
      fire(wa);
      k = 0;
      while (beat_q.size() < 16 * (e + 1) && k < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        b_en      = $urandom_range(0, 1) == 1;
        b_in      = 8'($urandom);
        step(1);
        k++;
      end
      b_en = 1'b0;
      out_ready = 1'b1;
      check($sformatf("rand word %0d beat count", e), beat_q.size(), 16 * (e + 1));
      check_word($sformatf("rand word %0d", e), wa, 16 * e);
    end
    check("rand overrun", overrun, 0);

    // ---------------- frame end
    do_reset();
    out_ready = 1'b1;
    to_cnt = 0;
    for (int p = 1; p <= 1260; p++) begin
      fire(zero);
      step(1);
      k = 0;
      while (busy && k < 40) begin
        step(1);
        k++;
      end
      if (busy) to_cnt++;
      if (p == 1259) check("frame_done before last", frame_done, 0);
      if (p == 1260) check("frame_done after last", frame_done, 1);
    end
    check("frame drain timeouts", to_cnt, 0);
    check("frame beat count", beat_q.size(), 1260 * 16);
    fire(zero);
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (out_valid) vcnt++;
    end
    check("frame 1261st valid cycles", vcnt, 0);
    check("frame busy in DONE", busy, 0);
    check("frame_done sticky", frame_done, 1);

    // ---------------- reset mid-EMIT
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) wa[i] = 5120 + i * 512;
    fire(wa);
    k = 0;
    while (!(out_valid && out_ch == 4'd7) && k < 40) begin
      step(1);
      k++;
    end
    check("mid reset reached ch7", {out_valid, out_ch}, {1'b1, 4'd7});
    #2;
    rst_n = 1'b0;
    conv_time = '0;
    #1;
    check("async reset outputs", {out_data, out_ch, out_valid, busy, overrun, frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat_q.delete();
    vcnt = 0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (out_valid) vcnt++;
    end
    check("post-reset valid cycles", vcnt, 0);
    check("post-reset beats", beat_q.size(), 0);
    fire(wa);
    wait_beats("post-reset word", 16, 40);
    check_word("post-reset word", wa, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
